// File: rtl/flanger_delay_line.sv
// flanger_delay_line
//   Circular-buffer SRAM controller feeding the flanger mixer. Each accepted
//   sample strobe writes the live sample at wr_ptr, reads back the sample
//   cur_delay positions behind it (once the buffer holds enough history) and
//   presents it on delayed_data with a one-cycle delayed_valid pulse.
//   cur_delay sweeps between MIN_DELAY and MAX_DELAY as a triangle, one step
//   every SWEEP_DIV processed samples.
//
//   Optional build macro: FLANGER_OVERRUN_EN adds a sticky 'overrun' output.
//
// Ports
//   clk, n_rst          clock, synchronous active-low reset
//   flanger_en          block enable; low aborts any access and parks in IDLE
//   shift_en, sample_in sample strobe and live sample
//   sram_req/we/addr/wdata, sram_rdata, sram_ack   SRAM handshake
//   delayed_data, delayed_valid   delayed sample to the mixer
//   busy                high whenever the FSM is not IDLE
//   cur_delay           current delay in samples
//   overrun             (FLANGER_OVERRUN_EN only) sticky dropped-work flag
//
// state | meaning
// IDLE  | waiting for shift_en with flanger_en high
// WRITE | writing latched sample at wr_ptr
// READ  | reading sample at wr_ptr - cur_delay
// DONE  | delayed_valid high; pointer, fill and sweep advance on exit
module flanger_delay_line #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MIN_DELAY = 16,
  parameter int MAX_DELAY = 512,
  parameter int SWEEP_DIV = 64
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flanger_en,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ack,
  output logic [DATA_W-1:0] delayed_data,
  output logic              delayed_valid,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_delay
`ifdef FLANGER_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int SWEEP_W = $clog2(SWEEP_DIV + 1);
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(SWEEP_DIV - 1);
  localparam logic [ADDR_W-1:0]  MIN_D      = ADDR_W'(MIN_DELAY);
  localparam logic [ADDR_W-1:0]  MAX_D      = ADDR_W'(MAX_DELAY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   fill_q, fill_d;
  logic [SWEEP_W-1:0]  sweep_cnt_q, sweep_cnt_d;
  logic                dir_down_q, dir_down_d;
  logic [ADDR_W-1:0]   cur_delay_q, cur_delay_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   next_delay;
`ifdef FLANGER_OVERRUN_EN
  logic                overrun_q, overrun_d;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    sweep_cnt_d = sweep_cnt_q;
    dir_down_d  = dir_down_q;
    cur_delay_d = cur_delay_q;
    wdata_d     = wdata_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    next_delay  = cur_delay_q;
    // Modulo 2^ADDR_W wrap falls out of the fixed-width subtraction.
    rd_addr     = wr_ptr_q - cur_delay_q;

    if (!flanger_en) begin
      // Abort: drop any in-flight sample, everything else holds.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (shift_en) begin
            wdata_d = sample_in;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (sram_ack) begin
            if (fill_q >= cur_delay_q) begin
              state_d = S_READ;
            end else begin
              state_d = S_DONE;
              dout_d  = '0;
              valid_d = 1'b1;
            end
          end
        end
        S_READ: begin
          if (sram_ack) begin
            state_d = S_DONE;
            dout_d  = sram_rdata;
            valid_d = 1'b1;
          end
        end
        S_DONE: begin
          state_d  = S_IDLE;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (fill_q < MAX_D) fill_d = fill_q + ADDR_W'(1);
          if (sweep_cnt_q == SWEEP_LAST) begin
            sweep_cnt_d = '0;
            next_delay  = dir_down_q ? (cur_delay_q - ADDR_W'(1)) : (cur_delay_q + ADDR_W'(1));
            cur_delay_d = next_delay;
            // Turn around on reaching either bound; clamp keeps the range safe.
            if (next_delay >= MAX_D) begin
              cur_delay_d = MAX_D;
              dir_down_d  = 1'b1;
            end else if (next_delay <= MIN_D) begin
              cur_delay_d = MIN_D;
              dir_down_d  = 1'b0;
            end
          end else begin
            sweep_cnt_d = sweep_cnt_q + SWEEP_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // SRAM outputs are registered from the next state.
    req_d  = (state_d == S_WRITE) || (state_d == S_READ);
    we_d   = (state_d == S_WRITE);
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_WRITE: addr_d = wr_ptr_d;
      S_READ:  addr_d = rd_addr;
      default: addr_d = '0;
    endcase

`ifdef FLANGER_OVERRUN_EN
    overrun_d = overrun_q;
    if ((state_q != S_IDLE) && (shift_en || !flanger_en)) begin
      overrun_d = 1'b1;
    end else if (!flanger_en && (state_q == S_IDLE)) begin
      overrun_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sweep_cnt_q <= '0;
      dir_down_q  <= 1'b0;
      cur_delay_q <= MIN_D;
      wdata_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
`ifdef FLANGER_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sweep_cnt_q <= sweep_cnt_d;
      dir_down_q  <= dir_down_d;
      cur_delay_q <= cur_delay_d;
      wdata_q     <= wdata_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
`ifdef FLANGER_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign sram_req      = req_q;
  assign sram_we       = we_q;
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign delayed_data  = dout_q;
  assign delayed_valid = valid_q;
  assign busy          = busy_q;
  assign cur_delay     = cur_delay_q;
`ifdef FLANGER_OVERRUN_EN
  assign overrun       = overrun_q;
`endif

endmodule
